// File: rtl/loopback_perf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : loopback_perf_scheduler
// Brief    : Sweeps the packet sender frame length over a range and reports
//            sent/received/cycle counts for each length step.
// Revision : 1.0 - initial release
// ============================================================================
module loopback_perf_scheduler #(
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             m_axis_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [9:0]       i_len_first,
    input  logic [9:0]       i_len_last,
    input  logic [9:0]       i_len_step,
    input  logic [CNT_W-1:0] i_pkts_per_step,
    input  logic             i_first_byte_sent,
    input  logic             i_sync_rx_last_received,
    output logic [9:0]       o_packet_bytes,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [9:0]       o_res_len,
    output logic [CNT_W-1:0] o_res_sent,
    output logic [CNT_W-1:0] o_res_rcvd,
    output logic [31:0]      o_res_cycles,
    output logic             o_res_timeout
);
    localparam int                c_tmr_w    = $clog2(DRAIN_TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state_q,       w_state_d;
    logic [9:0]         r_cur_len_q,     w_cur_len_d;
    logic [9:0]         r_len_last_q,    w_len_last_d;
    logic [9:0]         r_len_step_q,    w_len_step_d;
    logic [CNT_W-1:0]   r_pkts_q,        w_pkts_d;
    logic [CNT_W-1:0]   r_sent_q,        w_sent_d;
    logic [CNT_W-1:0]   r_rcvd_q,        w_rcvd_d;
    logic [31:0]        r_cycles_q,      w_cycles_d;
    logic [c_tmr_w-1:0] r_timer_q,       w_timer_d;
    logic [9:0]         r_pkt_bytes_q,   w_pkt_bytes_d;
    logic               r_busy_q,        w_busy_d;
    logic               r_done_q,        w_done_d;
    logic               r_res_valid_q,   w_res_valid_d;
    logic [9:0]         r_res_len_q,     w_res_len_d;
    logic [CNT_W-1:0]   r_res_sent_q,    w_res_sent_d;
    logic [CNT_W-1:0]   r_res_rcvd_q,    w_res_rcvd_d;
    logic [31:0]        r_res_cycles_q,  w_res_cycles_d;
    logic               r_res_timeout_q, w_res_timeout_d;

    logic               w_cfg_bad;
    logic [CNT_W-1:0]   w_rcvd_inc;
    logic [31:0]        w_cycles_inc;
    logic [10:0]        w_nxt;
    logic               w_drain_full;
    logic               w_drain_tmo;

    assign w_cfg_bad    = (i_len_first == 10'd0) || (i_len_first > i_len_last) ||
                          (i_pkts_per_step == '0);
    assign w_rcvd_inc   = (r_rcvd_q == '1) ? r_rcvd_q : r_rcvd_q + CNT_W'(1);
    assign w_cycles_inc = (r_cycles_q == '1) ? r_cycles_q : r_cycles_q + 32'd1;
    // 11-bit sum so a step past 1023 is caught instead of wrapping
    assign w_nxt        = {1'b0, r_cur_len_q} + {1'b0, r_len_step_q};
    assign w_drain_full = (r_rcvd_q == r_sent_q);
    assign w_drain_tmo  = (r_timer_q == c_tmr_last);

    always_comb begin
        w_state_d       = r_state_q;
        w_cur_len_d     = r_cur_len_q;
        w_len_last_d    = r_len_last_q;
        w_len_step_d    = r_len_step_q;
        w_pkts_d        = r_pkts_q;
        w_sent_d        = r_sent_q;
        w_rcvd_d        = r_rcvd_q;
        w_cycles_d      = r_cycles_q;
        w_timer_d       = r_timer_q;
        w_pkt_bytes_d   = r_pkt_bytes_q;
        w_res_valid_d   = r_res_valid_q;
        w_res_len_d     = r_res_len_q;
        w_res_sent_d    = r_res_sent_q;
        w_res_rcvd_d    = r_res_rcvd_q;
        w_res_cycles_d  = r_res_cycles_q;
        w_res_timeout_d = r_res_timeout_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_cur_len_d  = i_len_first;
                    w_len_last_d = i_len_last;
                    w_len_step_d = i_len_step;
                    w_pkts_d     = i_pkts_per_step;
                    if (w_cfg_bad) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_state_d     = S_RUN;
                        w_pkt_bytes_d = i_len_first;
                        w_sent_d      = '0;
                        w_rcvd_d      = '0;
                        w_cycles_d    = '0;
                    end
                end
            end
            S_RUN: begin
                w_cycles_d = w_cycles_inc;
                if (i_sync_rx_last_received) w_rcvd_d = w_rcvd_inc;
                if (i_first_byte_sent) begin
                    w_sent_d = r_sent_q + CNT_W'(1);
                    // Sender already latched its length for this last frame
                    if (r_sent_q + CNT_W'(1) == r_pkts_q) begin
                        w_state_d     = S_DRAIN;
                        w_pkt_bytes_d = '0;
                        w_timer_d     = '0;
                    end
                end
            end
            S_DRAIN: begin
                w_cycles_d = w_cycles_inc;
                w_timer_d  = r_timer_q + c_tmr_w'(1);
                if (i_sync_rx_last_received) w_rcvd_d = w_rcvd_inc;
                if (w_drain_full || w_drain_tmo) begin
                    w_state_d       = S_REPORT;
                    w_res_valid_d   = 1'b1;
                    w_res_len_d     = r_cur_len_q;
                    w_res_sent_d    = r_sent_q;
                    w_res_rcvd_d    = w_rcvd_d;
                    w_res_cycles_d  = w_cycles_inc;
                    w_res_timeout_d = !w_drain_full;
                end
            end
            S_REPORT: begin
                if (r_res_valid_q && i_res_ready) begin
                    w_res_valid_d = 1'b0;
                    if ((r_len_step_q == 10'd0) || (w_nxt > {1'b0, r_len_last_q}) || w_nxt[10]) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_state_d     = S_RUN;
                        w_cur_len_d   = w_nxt[9:0];
                        w_pkt_bytes_d = w_nxt[9:0];
                        w_sent_d      = '0;
                        w_rcvd_d      = '0;
                        w_cycles_d    = '0;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if (i_abort) begin
            w_state_d     = S_IDLE;
            w_pkt_bytes_d = '0;
            w_res_valid_d = 1'b0;
        end

        w_busy_d = (w_state_d == S_RUN) || (w_state_d == S_DRAIN) || (w_state_d == S_REPORT);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge m_axis_clk) begin
        if (i_reset) begin
            r_state_q       <= S_IDLE;
            r_cur_len_q     <= '0;
            r_len_last_q    <= '0;
            r_len_step_q    <= '0;
            r_pkts_q        <= '0;
            r_sent_q        <= '0;
            r_rcvd_q        <= '0;
            r_cycles_q      <= '0;
            r_timer_q       <= '0;
            r_pkt_bytes_q   <= '0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
            r_res_valid_q   <= 1'b0;
            r_res_len_q     <= '0;
            r_res_sent_q    <= '0;
            r_res_rcvd_q    <= '0;
            r_res_cycles_q  <= '0;
            r_res_timeout_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_cur_len_q     <= w_cur_len_d;
            r_len_last_q    <= w_len_last_d;
            r_len_step_q    <= w_len_step_d;
            r_pkts_q        <= w_pkts_d;
            r_sent_q        <= w_sent_d;
            r_rcvd_q        <= w_rcvd_d;
            r_cycles_q      <= w_cycles_d;
            r_timer_q       <= w_timer_d;
            r_pkt_bytes_q   <= w_pkt_bytes_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
            r_res_valid_q   <= w_res_valid_d;
            r_res_len_q     <= w_res_len_d;
            r_res_sent_q    <= w_res_sent_d;
            r_res_rcvd_q    <= w_res_rcvd_d;
            r_res_cycles_q  <= w_res_cycles_d;
            r_res_timeout_q <= w_res_timeout_d;
        end
    end

    assign o_packet_bytes = r_pkt_bytes_q;
    assign o_busy         = r_busy_q;
    assign o_done         = r_done_q;
    assign o_res_valid    = r_res_valid_q;
    assign o_res_len      = r_res_len_q;
    assign o_res_sent     = r_res_sent_q;
    assign o_res_rcvd     = r_res_rcvd_q;
    assign o_res_cycles   = r_res_cycles_q;
    assign o_res_timeout  = r_res_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_loopback_perf_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_loopback_perf_scheduler
// Brief    : Self-checking bench for the loopback length-sweep scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loopback_perf_scheduler;
    localparam int CNT_W = 16;
    localparam int DT    = 16;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic             i_abort;
    logic [9:0]       i_len_first;
    logic [9:0]       i_len_last;
    logic [9:0]       i_len_step;
    logic [CNT_W-1:0] i_pkts;
    logic             i_fbs;
    logic             i_rx;
    logic             i_ready;
    logic [9:0]       o_packet_bytes;
    logic             o_busy;
    logic             o_done;
    logic             o_res_valid;
    logic [9:0]       o_res_len;
    logic [CNT_W-1:0] o_res_sent;
    logic [CNT_W-1:0] o_res_rcvd;
    logic [31:0]      o_res_cycles;
    logic             o_res_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    loopback_perf_scheduler #(
        .CNT_W         (CNT_W),
        .DRAIN_TIMEOUT (DT)
    ) u_dut (
        .m_axis_clk              (clk),
        .i_reset                 (i_reset),
        .i_start                 (i_start),
        .i_abort                 (i_abort),
        .i_len_first             (i_len_first),
        .i_len_last              (i_len_last),
        .i_len_step              (i_len_step),
        .i_pkts_per_step         (i_pkts),
        .i_first_byte_sent       (i_fbs),
        .i_sync_rx_last_received (i_rx),
        .o_packet_bytes          (o_packet_bytes),
        .o_busy                  (o_busy),
        .o_done                  (o_done),
        .o_res_valid             (o_res_valid),
        .i_res_ready             (i_ready),
        .o_res_len               (o_res_len),
        .o_res_sent              (o_res_sent),
        .o_res_rcvd              (o_res_rcvd),
        .o_res_cycles            (o_res_cycles),
        .o_res_timeout           (o_res_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        if (obs !== req) begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One length step: open-loop sender/loopback schedule, expected record
    // derived from when frames are reported sent and looped back.
    task automatic run_step(input int exp_len, input int npk, input int bp, input bit drop_one);
        bit s_fbs [MAXC];
        bit s_rx  [MAXC];
        int t, lat, tf, dend, cnt, drop_idx;
        bit exp_to;
        for (int c = 0; c < MAXC; c++) begin
            s_fbs[c] = 1'b0;
            s_rx[c]  = 1'b0;
        end
        t        = int'($urandom_range(33, 1));
        lat      = int'($urandom_range(10, 3));
        drop_idx = drop_one ? int'($urandom_range(npk - 1, 0)) : -1;
        tf       = 0;
        for (int k = 0; k < npk; k++) begin
            s_fbs[t] = 1'b1;
            if (k != drop_idx) s_rx[t + lat] = 1'b1;
            tf = t;
            t += int'($urandom_range(6, 2));
        end
        dend   = -1;
        cnt    = 0;
        exp_to = 1'b0;
        for (int d = 0; d < MAXC && dend < 0; d++) begin
            if (d > tf && cnt == npk) begin
                dend   = d;
                exp_to = 1'b0;
            end else if (d > tf && (d - tf - 1) == DT - 1) begin
                dend   = d;
                exp_to = 1'b1;
            end
            cnt += int'(s_rx[d]);
        end

        for (int c = 0; c <= dend; c++) begin
            chk("run_packet_bytes", 32'(o_packet_bytes), 32'((c <= tf) ? exp_len : 0));
            chk("run_valid", 32'(o_res_valid), 32'(0));
            chk("run_busy", 32'(o_busy), 32'(1));
            i_fbs = s_fbs[c];
            i_rx  = s_rx[c];
            tick();
        end
        i_fbs = 1'b0;
        i_rx  = 1'b0;

        for (int r = 0; r <= bp; r++) begin
            chk("res_valid", 32'(o_res_valid), 32'(1));
            chk("res_len", 32'(o_res_len), 32'(exp_len));
            chk("res_sent", 32'(o_res_sent), 32'(npk));
            chk("res_rcvd", 32'(o_res_rcvd), 32'(cnt));
            chk("res_cycles", 32'(o_res_cycles), 32'(dend + 1));
            chk("res_timeout", 32'(o_res_timeout), 32'(exp_to));
            chk("report_packet_bytes", 32'(o_packet_bytes), 32'(0));
            i_ready = (r == bp);
            i_fbs   = (r != bp) ? 1'($urandom_range(1, 0)) : 1'b0;
            i_rx    = (r != bp) ? 1'($urandom_range(1, 0)) : 1'b0;
            tick();
        end
        i_ready = 1'b0;
        i_fbs   = 1'b0;
        i_rx    = 1'b0;
        chk("valid_after_handshake", 32'(o_res_valid), 32'(0));
    endtask

    task automatic sweep(input int f, input int l, input int s, input int p, input int bp, input bit drop);
        int lens[$];
        int cur;
        if (!(f == 0 || f > l || p == 0)) begin
            cur = f;
            forever begin
                lens.push_back(cur);
                if (s == 0 || cur + s > l || cur + s > 1023) break;
                cur += s;
            end
        end
        i_len_first = 10'(f);
        i_len_last  = 10'(l);
        i_len_step  = 10'(s);
        i_pkts      = CNT_W'(p);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        // Configuration must be ignored after the accepted start
        i_len_first = 10'($urandom);
        i_len_last  = 10'($urandom);
        i_len_step  = 10'($urandom);
        i_pkts      = CNT_W'($urandom);
        if (lens.size() == 0) begin
            for (int c = 0; c < 3; c++) begin
                chk("degen_done", 32'(o_done), 32'(1));
                chk("degen_valid", 32'(o_res_valid), 32'(0));
                chk("degen_packet_bytes", 32'(o_packet_bytes), 32'(0));
                tick();
            end
        end
        foreach (lens[i]) run_step(lens[i], p, bp, drop);
        chk("sweep_done", 32'(o_done), 32'(1));
        chk("sweep_busy", 32'(o_busy), 32'(0));
        chk("sweep_valid", 32'(o_res_valid), 32'(0));
        chk("sweep_packet_bytes", 32'(o_packet_bytes), 32'(0));
    endtask

    initial begin
        int f, l, s, p;
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_len_first = 10'd0;
        i_len_last  = 10'd0;
        i_len_step  = 10'd0;
        i_pkts      = '0;
        i_fbs       = 1'b0;
        i_rx        = 1'b0;
        i_ready     = 1'b0;
        repeat (3) tick();
        chk("rst_packet_bytes", 32'(o_packet_bytes), 32'(0));
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_done", 32'(o_done), 32'(0));
        chk("rst_valid", 32'(o_res_valid), 32'(0));
        chk("rst_len", 32'(o_res_len), 32'(0));
        chk("rst_sent", 32'(o_res_sent), 32'(0));
        chk("rst_rcvd", 32'(o_res_rcvd), 32'(0));
        chk("rst_cycles", 32'(o_res_cycles), 32'(0));
        chk("rst_timeout", 32'(o_res_timeout), 32'(0));
        i_reset = 1'b0;
        tick();
        chk("idle_busy", 32'(o_busy), 32'(0));

        sweep(64, 128, 32, 4, 1, 1'b0);      // basic sweep
        sweep(200, 200, 0, 4, 0, 1'b1);      // dropped frame -> drain timeout
        sweep(300, 400, 100, 2, 50, 1'b0);   // back-pressure
        sweep(0, 100, 10, 2, 0, 1'b0);       // degenerate configurations
        sweep(200, 100, 10, 2, 0, 1'b0);
        sweep(64, 128, 32, 0, 0, 1'b0);
        sweep(64, 64, 0, 3, 0, 1'b0);
        sweep(1000, 1023, 100, 2, 0, 1'b0);  // no wrap past 1023

        // Abort mid-RUN after two frames
        i_len_first = 10'd64;
        i_len_last  = 10'd128;
        i_len_step  = 10'd32;
        i_pkts      = CNT_W'(4);
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_fbs = (c == 3) || (c == 6);
            i_rx  = (c == 8);
            tick();
        end
        i_fbs   = 1'b0;
        i_rx    = 1'b0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_packet_bytes", 32'(o_packet_bytes), 32'(0));
        chk("abort_busy", 32'(o_busy), 32'(0));
        chk("abort_done", 32'(o_done), 32'(0));
        chk("abort_valid", 32'(o_res_valid), 32'(0));
        repeat (5) begin
            tick();
            chk("abort_idle_valid", 32'(o_res_valid), 32'(0));
        end
        sweep(100, 100, 0, 3, 0, 1'b0);

        // Start and abort together from DONE: abort wins
        i_len_first = 10'd64;
        i_len_last  = 10'd64;
        i_pkts      = CNT_W'(1);
        i_start     = 1'b1;
        i_abort     = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_abort_done", 32'(o_done), 32'(0));
        chk("start_abort_busy", 32'(o_busy), 32'(0));
        chk("start_abort_packet_bytes", 32'(o_packet_bytes), 32'(0));

        for (int it = 0; it < 6; it++) begin
            f = int'($urandom_range(900, 1));
            l = f + int'($urandom_range(400, 0));
            if (l > 1023) l = 1023;
            s = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(300, 90));
            p = int'($urandom_range(5, 1));
            sweep(f, l, s, p, int'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
